// File: rtl/mem_load_if.sv
// mem_load_if: loader control/status bundle between a sequencer and mem_load.
interface mem_load_if #(parameter int DATA_W = 16);
  logic              clear;
  logic              step_load;
  logic [DATA_W-1:0] din;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              busy;
  logic              full;
  logic [15:0]       checksum;
  modport master (output clear, step_load, din, input addr, wdata, we, busy, full, checksum);
  modport slave  (input clear, step_load, din, output addr, wdata, we, busy, full, checksum);
endinterface

// File: rtl/mem_load.sv
// mem_load: steps words into sequential memory addresses, stopping at the last address.
// Optional running checksum of written words when MEM_LOAD_CHECKSUM_EN is defined.
module mem_load #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16
) (
  input logic     clk,
  input logic     reset,
  mem_load_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, ADVANCE, FULL} state_t;
  localparam logic [15:0] LAST = 16'(DEPTH - 1);
  state_t            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (bus.clear) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.step_load) begin
          state_d = WRITE;
          wdata_d = bus.din;
        end
        WRITE: state_d = ADVANCE;
        ADVANCE: begin
          state_d = (addr_q == LAST) ? FULL : IDLE;
          addr_d  = (addr_q == LAST) ? addr_q : addr_q + 16'd1;
        end
        default: state_d = FULL;
      endcase
    end
  end
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.we    = state_q == WRITE;
  assign bus.busy  = state_q == WRITE || state_q == ADVANCE;
  assign bus.full  = state_q == FULL;
`ifdef MEM_LOAD_CHECKSUM_EN
  logic [15:0] csum_q;
  // Accumulate on the ADVANCE edge so an aborted WRITE never contributes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= bus.clear ? '0 : (state_q == ADVANCE ? csum_q + 16'(wdata_q) : csum_q);
  end
  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule
